// File: rtl/led_blink_sched_pkg.sv
// Shared constants for the LED blink scheduler: requester count, field widths
// and the legacy-compatible FSM state encoding.
package led_pkg;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned ID_W   = 2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned TCNT_W = 8;
  localparam int unsigned DIV_W  = 24;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

endpackage

// File: rtl/led_blink_sched_if.sv
// Request/ack bundle between requesters (master) and the blink scheduler (slave).
interface led_blink_sched_if;
  import led_pkg::*;

  logic [N_REQ-1:0]       req;
  logic [N_REQ*CNT_W-1:0] req_cnt;
  logic                   led;
  logic [N_REQ-1:0]       ack;
  logic                   busy;
  logic [ID_W-1:0]        active_id;

  modport master (output req, req_cnt, input led, ack, busy, active_id);
  modport slave  (input req, req_cnt, output led, ack, busy, active_id);

endinterface

// File: rtl/led_blink_sched_tick_gen.sv
// Prescaler: counts 0..TICK_DIV and flags the terminal count; clr restarts the period.
module tick_gen
  import led_pkg::*;
#(
  parameter logic [DIV_W-1:0] TICK_DIV = 24'h3cf008
) (
  input  logic clk,
  input  logic reset_,
  input  logic clr,
  output logic tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // tick is a pure decode of the count so it can feed the FSM without a loop through clr
  assign tick = (cnt_q == TICK_DIV);

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_blink_sched.sv
// Round-robin LED blink scheduler: serves one requester at a time with N blinks
// followed by a dark gap, then pulses that requester's ack.
module led_blink_sched
  import led_pkg::*;
#(
  parameter logic [DIV_W-1:0] TICK_DIV  = 24'h3cf008,
  parameter int unsigned      ON_TICKS  = 1,
  parameter int unsigned      OFF_TICKS = 1,
  parameter int unsigned      GAP_TICKS = 4
) (
  input  logic clk,
  input  logic reset_,
  led_blink_sched_if.slave bus
);

  localparam logic [TCNT_W-1:0] ON_LAST  = TCNT_W'(ON_TICKS - 1);
  localparam logic [TCNT_W-1:0] OFF_LAST = TCNT_W'(OFF_TICKS - 1);
  localparam logic [TCNT_W-1:0] GAP_LAST = TCNT_W'(GAP_TICKS - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [ID_W-1:0]   active_id_q, active_id_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              led_q, led_d;
  logic              busy_q, busy_d;
  logic              tick;
  logic              clr_c;
  logic              found_c;
  logic [ID_W-1:0]   idx_c;
  logic [N_REQ-1:0]  pend_c;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk    (clk),
    .reset_ (reset_),
    .clr    (clr_c),
    .tick   (tick)
  );

  // Next-state, tick-in-state counting, arbitration and registered output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tcnt_d      = tcnt_q;
    active_id_d = active_id_q;
    ack_d       = '0;
    found_c     = 1'b0;
    idx_c       = '0;
    // a requester still holding req during its own ack cycle must not be re-granted
    pend_c      = bus.req & ~ack_q;

    if (tick) tcnt_d = tcnt_q + TCNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        for (int unsigned k = 1; k <= N_REQ; k++) begin
          idx_c = active_id_q + ID_W'(k);
          if (!found_c && pend_c[idx_c]) begin
            found_c     = 1'b1;
            active_id_d = idx_c;
            cnt_d       = bus.req_cnt[idx_c*CNT_W +: CNT_W];
            state_d     = (cnt_d != '0) ? ST_ON : ST_GAP;
          end
        end
      end
      ST_ON: begin
        if (tick && tcnt_q == ON_LAST) state_d = ST_OFF;
      end
      ST_OFF: begin
        if (tick && tcnt_q == OFF_LAST) begin
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = (cnt_q > CNT_W'(1)) ? ST_ON : ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick && tcnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          ack_d   = N_REQ'(1) << active_id_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // every grant is also a state change, so one clear covers both
    clr_c = (state_d != state_q);
    if (clr_c) tcnt_d = '0;

    led_d  = (state_d == ST_ON);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      active_id_q <= '1;
      ack_q       <= '0;
      led_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tcnt_q      <= tcnt_d;
      active_id_q <= active_id_d;
      ack_q       <= ack_d;
      led_q       <= led_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.led       = led_q;
  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;
  assign bus.active_id = active_id_q;

endmodule
